// File: rtl/dmem_responder_if.sv
// Load/store request and load-response bundle between the datapath MEM stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ASIZE = 16,
  parameter int DSIZE = 16
) ();
  logic             req_valid;
  logic             req_we;
  logic [ASIZE-1:0] req_addr;
  logic [DSIZE-1:0] req_wdata;
  logic             req_ready;
  logic             rsp_valid;
  logic [DSIZE-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores go through a small store buffer that drains
// into a word array; loads forward from the buffer or take a multi-cycle array read.
module dmem_responder #(
  parameter int DSIZE    = 16,
  parameter int ASIZE    = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  dmem_responder_if.slave           bus,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(READ_LAT + 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rd_idx;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic [AW-1:0]    sb_idx  [SB_DEPTH];
  logic [DSIZE-1:0] sb_data [SB_DEPTH];
  logic [DSIZE-1:0] mem     [DEPTH];
  logic             rsp_valid_q;
  logic [DSIZE-1:0] rsp_rdata_q;

  logic [AW-1:0]    req_idx, mem_idx;
  logic [DSIZE-1:0] fwd_data, mem_q;
  logic             hit, sb_full, ld_ready, ready;
  logic             st_acc, ld_acc, hit_acc, miss_acc, drain;
  logic             addr_unused;

  assign req_idx = bus.req_addr[AW-1:0];

  if (ASIZE > AW) begin : g_hi_bits
    assign addr_unused = ^bus.req_addr[ASIZE-1:AW];
  end else begin : g_no_hi_bits
    assign addr_unused = 1'b0;
  end

  // Walk oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (i < 32'(count) && sb_idx[head + PW'(i)] == req_idx) begin
        hit      = 1'b1;
        fwd_data = sb_data[head + PW'(i)];
      end
    end
  end

  assign sb_full  = (count == (PW+1)'(SB_DEPTH));
  assign ld_ready = (state == IDLE) && !(!hit && sb_full);
  assign ready    = bus.req_we ? !sb_full : ld_ready;

  assign st_acc   = bus.req_valid &&  bus.req_we && ready;
  assign ld_acc   = bus.req_valid && !bus.req_we && ready;
  assign hit_acc  = ld_acc &&  hit;
  assign miss_acc = ld_acc && !hit;
  assign drain    = (state == IDLE) && !miss_acc && (count != '0);

  // The array is untouched while READ, so sampling it at the response edge is safe.
  assign mem_idx = (state == IDLE) ? req_idx : rd_idx;
  assign mem_q   = mem[mem_idx];

  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_idx[tail]  <= req_idx;
      sb_data[tail] <= bus.req_wdata;
    end
    if (drain) mem[sb_idx[head]] <= sb_data[head];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_idx      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (st_acc) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      case ({st_acc, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (hit_acc) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= fwd_data;
          end else if (miss_acc) begin
            state  <= READ;
            cnt    <= CW'(1);
            rd_idx <= req_idx;
            if (READ_LAT == 1) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= mem_q;
            end
          end
        end
        READ: begin
          if (cnt == CW'(READ_LAT)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(READ_LAT - 1)) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= mem_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sb_count      = count;
  assign sb_empty      = (count == '0);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It is the other end of the load/store interface that the datapath drives.
- Accepts one load or store request per cycle and posts stores into a small store buffer. Buffered stores drain into an internal single-port word array.
- Serves loads either by forwarding from the store buffer (1 cycle) or by a multi-cycle array read.
- Sits between the datapath's MEM stage and data storage; its stall output feeds the hazard/stall logic.

Parameters:
DSIZE, 16, data word width
ASIZE, 16, request address width
DEPTH, 256, array words; power of 2; index = req_addr[log2(DEPTH)-1:0], upper bits ignored (wrap)
READ_LAT, 2, array read latency in cycles, >=1
SB_DEPTH, 4, store-buffer entries, power of 2, >=2

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_we  in  1  1 = store, 0 = load
req_addr  in  ASIZE  word address
req_wdata  in  DSIZE  store data
req_ready  out  1  request accepted this cycle when req_valid && req_ready
rsp_valid  out  1  one-cycle pulse, load data valid
rsp_rdata  out  DSIZE  load data; holds last value when rsp_valid=0
sb_count  out  log2(SB_DEPTH)+1  occupied store-buffer entries
sb_empty  out  1  sb_count==0 (fence/drain-complete indication)

Behaviour:
- Reset (rst=0, async): FSM=IDLE, store buffer emptied, read counter=0, rsp_valid=0, rsp_rdata=0, sb_count=0, sb_empty=1.
  - Array contents are not reset.
  - A reset mid-operation drops any pending read (no rsp) and discards all buffered stores.
- FSM states:
  - IDLE: array free.
  - READ: array busy, counter runs 1..READ_LAT.
- req_ready (combinational from registered state only; no same-cycle drain bypass):
  - store: ready = !sb_full. This holds in any state.
  - load: ready = (state==IDLE) && !(miss && sb_full). A full buffer forces a drain before any load miss, which prevents drain starvation.
  - Load hit while full is allowed.
- Store accept: entry {addr index, data} enqueued at tail; sb_count+1 next cycle. No response is generated (posted write).
- Load accept, forward hit (any entry's index matches):
  - Data comes from the youngest matching entry, including an entry being drained in the same cycle.
  - rsp_valid=1 with that data on the next cycle; state stays IDLE.
- Load accept, miss:
  - IDLE->READ and the array read is issued.
  - rsp_valid=1 exactly READ_LAT cycles after the accept edge; then READ->IDLE.
  - The next load may be accepted in the cycle after rsp_valid.
- Drain:
  - In IDLE, when no load miss is accepted that cycle and the buffer is non-empty, the head entry is written to the array and dequeued.
  - At most one drain per cycle.
  - Priority: forced drain (full) > load miss > drain.
- Stores may be accepted during READ; they wait for IDLE to drain.
- Simultaneous store-accept and drain: sb_count is unchanged; the head/tail pointers wrap modulo SB_DEPTH.
- Ordering:
  - Stores reach the array in program order.
  - A load always returns the value of the latest earlier store to the same index; no stale array data is returned while a matching entry is buffered.
- Addresses >= DEPTH alias onto index addr mod DEPTH, for both forwarding compare and array access.

Test Plan:
- Reset, then idle 3 cycles -> rsp_valid=0, rsp_rdata=0x0000, sb_empty=1, req_ready=1 for both load and store.
- Store 0x1234 to addr 5, next cycle load addr 5 -> forward hit; rsp_valid on following cycle, rsp_rdata=0x1234.
- Store 0xAAAA then 0xBBBB to addr 7, immediate load 7 -> rsp_rdata=0xBBBB (youngest entry).
- Store 0x00FF to addr 3, wait for sb_empty=1, load 3 with READ_LAT=2 -> rsp_valid exactly 2 cycles after accept, data 0x00FF. During those 2 cycles, a load has req_ready=0 and a store has req_ready=1.
- Four stores back-to-back during a READ (SB_DEPTH=4):
  - Fifth store sees req_ready=0, and a load miss also sees req_ready=0.
  - Drains begin in the first IDLE cycle; sb_count decrements 4->3.
  - Load to addr 0x0105 with DEPTH=256 aliases to index 5.
- Assert rst low mid-READ with 2 buffered stores -> no rsp_valid pulse, sb_count=0 immediately. After release, a load of the buffered address returns the pre-store array value, not the discarded data.
